pcie_cpld_realign: RTL and testbench
====================================

// Module: pcie_cpld_realign
// PURPOSE
// Completion-with-data (CplD) extractor/realigner between the PCIe HIP RX Avalon-ST source and the DMA data sink.
// Strips the 3DW CplD header and shifts payload so payload DW0 lands at bit 0 of the output; emits length-exact beats with byte empty.
// Successor to the fixed 256-bit CplD path: width-parametrised, backpressure-aware, tag/last-completion sideband, drops non-CplD/errored TLPs.
// PARAMETERS
// DATA_W     256  RX/out data width in bits; legal 128, 256, 512 (N = DATA_W/32 DWs per beat)
// MAX_LEN_DW 256  largest accepted CplD length in DW; longer TLPs are dropped as malformed
// CNT_W      16   width of drop/error counters (saturating)
// PORTS
// clock          in   1                  core clock
// reset_n        in   1                  asynchronous, active-low reset
// rx_data        in   DATA_W             RX TLP data, DW0 of TLP at bits [31:0] of SOP beat
// rx_valid       in   1                  RX beat valid
// rx_sop/rx_eop  in   1/1                start/end of TLP
// rx_ready       out  1                  RX beat accepted when rx_valid & rx_ready
// out_data       out  DATA_W             realigned payload, payload DW0 at [31:0] of first beat
// out_valid      out  1                  output beat valid
// out_ready      in   1                  sink ready
// out_sop/out_eop out 1/1                first/last beat of one completion's payload
// out_empty      out  $clog2(DATA_W/8)   unused bytes in eop beat (multiple of 4); 0 otherwise
// out_tag        out  8                  tag of current completion, stable sop..eop
// out_last_cpl   out  1                  at eop: byte count == length*4 - lower_addr[1:0] (final CplD of request)
// drop_cnt       out  CNT_W              non-CplD or malformed TLPs discarded
// err_cnt        out  CNT_W              CplD/Cpl with status != SC discarded
// BEHAVIOUR
// - Reset (reset_n low, async): out_valid=0, out_sop=0, out_eop=0, out_empty=0, out_tag=0, out_last_cpl=0, out_data=0, drop_cnt=0, err_cnt=0, state=IDLE; rx_ready=0 while in reset.
// - Header decode on SOP beat: fmt/type=DW0[31:24] must equal 0x4A; len=DW0[9:0] (0 means 1024); status=DW1[15:13]; byte_cnt=DW1[11:0]; tag=DW2[15:8]; payload starts at DW3 of SOP beat, no padding. One TLP per beat; SOP only at DW0.
// - States: IDLE -> STREAM (CplD, status 0, len<=MAX_LEN_DW, len>N-3); IDLE -> FLUSH (same, len<=N-3, sop&eop beat); IDLE -> DROP (other TLP or errored CplD, when not eop); DROP -> IDLE on eop beat; STREAM -> FLUSH on eop beat if carry DWs remain, else IDLE; FLUSH -> IDLE when flush beat accepted.
// - Drop/err decision on SOP beat: type!=0x4A or len>MAX_LEN_DW -> drop_cnt+1; type 0x4A/0x0A with status!=0 -> err_cnt+1. Counters saturate at all-ones. Dropped beats are consumed (rx_ready=1), never output.
// - Datapath: carry register holds upper N-3 DWs of previous beat; STREAM output beat = {cur[3*32-1:0], carry}; rem_dw decrements by N per output beat.
// - Output beat registered 1 cycle after the input beat that completes it; FLUSH beat = {0, carry} with rem_dw DWs valid.
// - out_empty on eop = (N - rem_dw)*4 bytes; unused DWs driven 0.
// - Handshake: rx_ready = reset_n & (state!=FLUSH) & (!out_valid | out_ready). Output holds data/sideband stable while out_valid & !out_ready. Full throughput (1 beat/cycle) with out_ready=1.
// - Input beats after len exhausted but before eop (e.g. ECRC/pad) are consumed and discarded.
// - rx_sop while in STREAM: abort current completion (emit nothing further, out_eop not generated), drop_cnt+1, decode new SOP.
// - Reset mid-packet: all state cleared; residual beats of that TLP seen after reset (no SOP) are ignored in IDLE.
// TESTING
// 1 DATA_W=256, CplD len=1 tag 0x00, DW3=0x00010000 -> one beat, out_data[31:0]=0x00010000, out_empty=28, sop=eop=1, out_last_cpl=1.
// 2 len=4, DW3..DW6=0x00010000,0x00030002,0x00050004,0x00070006 -> one beat, out_data[127:0]=0x00070006_00050004_00030002_00010000, out_empty=16.
// 3 len=16 (3 RX beats, payload 0x00010000..0x001F001E) -> 2 out beats, 2nd beat [31:0]=0x00110010, out_empty=0, eop on 2nd.
// 4 len=16 with out_ready toggling 1/0 every cycle -> identical data to (3), no beat lost or duplicated, out_data stable while stalled.
// 5 MRd TLP (DW0=0x00000001) then CplD status=UR (DW1[15:13]=1) -> drop_cnt=1, err_cnt=1, no out_valid; following good CplD passes.
// 6 Assert reset_n=0 after 2nd beat of len=32 CplD, release, send len=1 CplD -> only len=1 beat output, counters 0; repeat (1)-(3) with DATA_W=128 and 512.

Source files
------------

// File: rtl/pcie_cpld_realign.sv
// pcie_cpld_realign
//   Extracts the payload of Completion-with-Data TLPs arriving on the PCIe HIP
//   RX Avalon-ST source. It strips the 3DW header and realigns the payload so
//   that payload DW0 sits at bit 0 of the first output beat. Output beats are
//   length-exact: DWs past the end of the payload are driven to zero and
//   out_empty reports the unused bytes on the eop beat. Non-CplD and malformed
//   TLPs are counted in drop_cnt. Completions with a non-successful status are
//   counted in err_cnt. Neither kind ever reaches the output.
//
// Ports
//   clock, reset_n      core clock, asynchronous active-low reset
//   rx_data/valid/sop/eop/ready
//                       RX TLP stream; TLP DW0 is at [31:0] of the SOP beat
//   out_data/valid/ready/sop/eop/empty
//                       realigned payload stream, one completion per sop..eop
//   out_tag             tag of the completion currently on the output
//   out_last_cpl        on eop: this CplD finishes its request
//   drop_cnt, err_cnt   saturating discard counters
module pcie_cpld_realign #(
   parameter int DATA_W     = 256,
   parameter int MAX_LEN_DW = 256,
   parameter int CNT_W      = 16
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic [DATA_W-1:0]             rx_data,
   input  logic                          rx_valid,
   input  logic                          rx_sop,
   input  logic                          rx_eop,
   output logic                          rx_ready,
   output logic [DATA_W-1:0]             out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          out_sop,
   output logic                          out_eop,
   output logic [$clog2(DATA_W/8)-1:0]   out_empty,
   output logic [7:0]                    out_tag,
   output logic                          out_last_cpl,
   output logic [CNT_W-1:0]              drop_cnt,
   output logic [CNT_W-1:0]              err_cnt
);

   localparam int N  = DATA_W / 32;        // DWs per beat
   localparam int CW = DATA_W - 96;        // carry width: upper N-3 DWs
   localparam int EW = $clog2(DATA_W / 8);

   typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DROP} state_t;

   // Keeps DWs [0, cnt) of a beat and zeroes the rest.
   function automatic logic [DATA_W-1:0] dw_mask(input logic [10:0] cnt);
      logic [DATA_W-1:0] m;
      m = '0;
      for (int i = 0; i < N; i++) begin
         if (11'(i) < cnt) begin
            m[i*32 +: 32] = 32'hFFFF_FFFF;
         end else begin
            m[i*32 +: 32] = 32'h0000_0000;
         end
      end
      return m;
   endfunction

   // Counter increment that sticks at all-ones.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                                input logic [1:0] inc);
      logic [CNT_W:0] s;
      s = {1'b0, c} + {{(CNT_W-1){1'b0}}, inc};
      return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

   state_t            state_r, state_s;
   logic [CW-1:0]     carry_r, carry_s;
   logic [10:0]       rem_r, rem_s;           // payload DWs not yet emitted
   logic [7:0]        tag_r, tag_s;
   logic              last_r, last_s;
   logic              first_r, first_s;       // next emitted beat is the sop beat

   logic [DATA_W-1:0] out_data_r;
   logic              out_valid_r, out_sop_r, out_eop_r, out_last_r;
   logic [EW-1:0]     out_empty_r;
   logic [7:0]        out_tag_r;
   logic [CNT_W-1:0]  drop_cnt_r, err_cnt_r;

   logic              adv_s, acc_s, load_s;
   logic [DATA_W-1:0] ld_data_s;
   logic              ld_sop_s, ld_eop_s, ld_last_s;
   logic [EW-1:0]     ld_empty_s;
   logic [1:0]        drop_inc_s;
   logic              err_inc_s;

   // Header fields of the SOP beat.
   logic [10:0]       len_s;
   logic [12:0]       bc_s;
   logic [7:0]        fmt_type_s;
   logic [2:0]        status_s;
   logic              last_calc_s;

   assign fmt_type_s  = rx_data[31:24];
   assign len_s       = (rx_data[9:0] == 10'd0) ? 11'd1024 : {1'b0, rx_data[9:0]};
   assign status_s    = rx_data[47:45];
   // A byte count of zero encodes 4096 bytes.
   assign bc_s        = (rx_data[43:32] == 12'd0) ? 13'd4096 : {1'b0, rx_data[43:32]};
   assign last_calc_s = (bc_s == ({len_s, 2'b00} - {11'd0, rx_data[65:64]}));

   // Output register may take a new beat when empty or draining this cycle.
   assign adv_s    = ~out_valid_r | out_ready;
   assign rx_ready = reset_n & (state_r != FLUSH) & adv_s;
   assign acc_s    = rx_valid & rx_ready;

   // Next-state, datapath and counter-increment decode.
   always_comb begin
      state_s    = state_r;
      carry_s    = carry_r;
      rem_s      = rem_r;
      tag_s      = tag_r;
      last_s     = last_r;
      first_s    = first_r;
      load_s     = 1'b0;
      ld_data_s  = '0;
      ld_sop_s   = 1'b0;
      ld_eop_s   = 1'b0;
      ld_last_s  = 1'b0;
      ld_empty_s = '0;
      drop_inc_s = 2'd0;
      err_inc_s  = 1'b0;

      if (state_r == FLUSH) begin
         if (adv_s) begin
            load_s     = 1'b1;
            ld_data_s  = {{96{1'b0}}, carry_r} & dw_mask(rem_r);
            ld_sop_s   = first_r;
            ld_eop_s   = 1'b1;
            ld_last_s  = last_r;
            ld_empty_s = EW'((N - int'(rem_r)) * 4);
            first_s    = 1'b0;
            rem_s      = 11'd0;
            state_s    = IDLE;
         end else begin
            state_s = FLUSH;
         end
      end else if (acc_s) begin
         if (rx_sop) begin
            // A new SOP inside a completion aborts it as malformed.
            if (state_r == STREAM) begin
               drop_inc_s = 2'd1;
            end else begin
               drop_inc_s = 2'd0;
            end
            if (((fmt_type_s == 8'h4A) || (fmt_type_s == 8'h0A)) && (status_s != 3'd0)) begin
               err_inc_s = 1'b1;
               state_s   = rx_eop ? IDLE : DROP;
            end else if ((fmt_type_s != 8'h4A) || (len_s > 11'(MAX_LEN_DW))) begin
               drop_inc_s = drop_inc_s + 2'd1;
               state_s    = rx_eop ? IDLE : DROP;
            end else begin
               carry_s = rx_data[DATA_W-1:96];
               rem_s   = len_s;
               tag_s   = rx_data[79:72];
               last_s  = last_calc_s;
               first_s = 1'b1;
               // Short payloads fit entirely in the SOP beat; any trailing
               // beats of the TLP are then swallowed in IDLE.
               if (len_s <= 11'(N - 3)) begin
                  state_s = FLUSH;
               end else begin
                  state_s = STREAM;
               end
            end
         end else begin
            case (state_r)
               STREAM: begin
                  load_s    = 1'b1;
                  ld_data_s = {rx_data[95:0], carry_r} & dw_mask(rem_r);
                  ld_sop_s  = first_r;
                  first_s   = 1'b0;
                  if (rem_r <= 11'(N)) begin
                     ld_eop_s   = 1'b1;
                     ld_last_s  = last_r;
                     ld_empty_s = EW'((N - int'(rem_r)) * 4);
                     rem_s      = 11'd0;
                     // Beats after the payload (ECRC, pad) are consumed silently.
                     state_s    = rx_eop ? IDLE : DROP;
                  end else begin
                     rem_s   = rem_r - 11'(N);
                     carry_s = rx_data[DATA_W-1:96];
                     if (rem_s <= 11'(N - 3)) begin
                        state_s = FLUSH;
                     end else if (rx_eop) begin
                        // TLP ended before its declared length.
                        drop_inc_s = 2'd1;
                        state_s    = IDLE;
                     end else begin
                        state_s = STREAM;
                     end
                  end
               end
               DROP: begin
                  if (rx_eop) begin
                     state_s = IDLE;
                  end else begin
                     state_s = DROP;
                  end
               end
               default: begin
                  state_s = state_r;
               end
            endcase
         end
      end else begin
         state_s = state_r;
      end
   end

   // Control state, carry and per-completion context.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
         carry_r <= '0;
         rem_r   <= 11'd0;
         tag_r   <= 8'd0;
         last_r  <= 1'b0;
         first_r <= 1'b0;
      end else begin
         state_r <= state_s;
         carry_r <= carry_s;
         rem_r   <= rem_s;
         tag_r   <= tag_s;
         last_r  <= last_s;
         first_r <= first_s;
      end
   end

   // Output beat register; holds while the sink stalls.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_data_r  <= '0;
         out_valid_r <= 1'b0;
         out_sop_r   <= 1'b0;
         out_eop_r   <= 1'b0;
         out_empty_r <= '0;
         out_tag_r   <= 8'd0;
         out_last_r  <= 1'b0;
      end else if (load_s) begin
         out_data_r  <= ld_data_s;
         out_valid_r <= 1'b1;
         out_sop_r   <= ld_sop_s;
         out_eop_r   <= ld_eop_s;
         out_empty_r <= ld_empty_s;
         out_tag_r   <= tag_r;
         out_last_r  <= ld_last_s;
      end else if (out_ready) begin
         out_valid_r <= 1'b0;
      end
   end

   // Saturating discard counters.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         drop_cnt_r <= '0;
         err_cnt_r  <= '0;
      end else begin
         drop_cnt_r <= sat_add(drop_cnt_r, drop_inc_s);
         err_cnt_r  <= sat_add(err_cnt_r, {1'b0, err_inc_s});
      end
   end

   assign out_data     = out_data_r;
   assign out_valid    = out_valid_r;
   assign out_sop      = out_sop_r;
   assign out_eop      = out_eop_r;
   assign out_empty    = out_empty_r;
   assign out_tag      = out_tag_r;
   assign out_last_cpl = out_last_r;
   assign drop_cnt     = drop_cnt_r;
   assign err_cnt      = err_cnt_r;

endmodule

// File: tb/tb_pcie_cpld_realign.sv
// Scoreboard bench for pcie_cpld_realign at DATA_W = 128, 256 and 512.
// TLPs are built as DW lists. The expected output beats come straight from
// the payload DWs, packed N per beat from bit 0. They are queued when a TLP is
// sent and compared when the selected DUT presents a beat.
module tb_pcie_cpld_realign;

   typedef struct {
      logic [511:0] data;
      logic         sop;
      logic         eop;
      logic [7:0]   empty;
      logic [7:0]   tag;
      logic         last;
   } beat_t;

   beat_t        exp_q[$];
   logic         clk = 1'b0;
   logic         rst_n;
   logic [511:0] rx_data;
   logic         rx_valid, rx_sop, rx_eop, out_ready;
   bit           toggle;
   int           sel, n_dw;
   int           err_count = 0;
   int           chk_count = 0;

   logic [511:0] od[3];
   logic         ov[3], osop[3], oeop[3], olast[3], rrdy[3];
   logic [7:0]   oemp[3], otag[3];
   logic [15:0]  dcnt[3], ecnt[3];

   always #5 clk = ~clk;

   for (genvar k = 0; k < 3; k++) begin : g_dut
      localparam int W = 128 << k;
      logic [W-1:0]             od_l;
      logic [$clog2(W/8)-1:0]   emp_l;
      pcie_cpld_realign #(.DATA_W(W), .MAX_LEN_DW(256), .CNT_W(16)) dut (
         .clock(clk), .reset_n(rst_n),
         .rx_data(rx_data[W-1:0]), .rx_valid(rx_valid && (sel == k)),
         .rx_sop(rx_sop), .rx_eop(rx_eop), .rx_ready(rrdy[k]),
         .out_data(od_l), .out_valid(ov[k]), .out_ready(out_ready),
         .out_sop(osop[k]), .out_eop(oeop[k]), .out_empty(emp_l),
         .out_tag(otag[k]), .out_last_cpl(olast[k]),
         .drop_cnt(dcnt[k]), .err_cnt(ecnt[k]));
      assign od[k]   = 512'(od_l);
      assign oemp[k] = 8'(emp_l);
   end

   task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] expv);
      chk_count++;
      if (obs !== expv) begin
         err_count++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Sink readiness: always ready, or alternating every cycle.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = toggle ? ~out_ready : 1'b1;
      end
   end

   // Compare every presented beat (stalled or not) against the queue head.
   always @(negedge clk) begin
      if (rst_n && ov[sel]) begin
         if (exp_q.size() == 0) begin
            check_val("unexpected_beat", 512'(ov[sel]), 512'(0));
         end else begin
            check_val(out_ready ? "data" : "stall_data", od[sel], exp_q[0].data);
            check_val("sop", 512'(osop[sel]), 512'(exp_q[0].sop));
            check_val("eop", 512'(oeop[sel]), 512'(exp_q[0].eop));
            check_val("empty", 512'(oemp[sel]), 512'(exp_q[0].empty));
            check_val("tag", 512'(otag[sel]), 512'(exp_q[0].tag));
            check_val("last_cpl", 512'(olast[sel]), 512'(exp_q[0].last));
            if (out_ready) begin
               void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic wait_accept();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (rrdy[sel]) done = 1'b1;
         @(posedge clk);
         #1;
      end
      check_val("rx_accept", 512'(done), 512'(1));
   endtask

   // Sends beats b_lo..b_hi of a TLP. exp_beats: -1 expect the whole payload,
   // 0 expect nothing, n>0 expect only the first n beats with no eop.
   task automatic send_tlp(input logic [7:0] fmt, input int len, input logic [7:0] tag,
                           input logic [2:0] status, input logic [11:0] bc,
                           input int b_lo, input int b_hi, input int exp_beats);
      logic [31:0] dws[$];
      beat_t       b;
      int          nexp, cnt, total, nb;
      logic [12:0] bc13;
      dws.push_back({fmt, 14'h0, 10'(len)});
      dws.push_back({16'h0100, status, 1'b0, bc});
      dws.push_back({16'h0200, tag, 8'h00});
      for (int i = 0; i < len; i++) dws.push_back({16'(2*i+1), 16'(2*i)});
      bc13 = (bc == 12'd0) ? 13'd4096 : {1'b0, bc};
      if (exp_beats != 0) begin
         nexp = (len + n_dw - 1) / n_dw;
         for (int j = 0; j < nexp && (exp_beats < 0 || j < exp_beats); j++) begin
            cnt = (len - j*n_dw > n_dw) ? n_dw : len - j*n_dw;
            b.data = '0;
            for (int d = 0; d < cnt; d++) b.data[d*32 +: 32] = dws[3 + j*n_dw + d];
            b.sop   = (j == 0);
            b.eop   = (j == nexp - 1) && (exp_beats < 0);
            b.empty = b.eop ? 8'((n_dw - cnt) * 4) : 8'd0;
            b.tag   = tag;
            b.last  = b.eop && (bc13 == 13'(len * 4));
            exp_q.push_back(b);
         end
      end
      total = dws.size();
      nb    = (total + n_dw - 1) / n_dw;
      for (int bi = b_lo; bi <= b_hi && bi < nb; bi++) begin
         rx_data = '0;
         for (int d = 0; d < n_dw; d++)
            rx_data[d*32 +: 32] = (bi*n_dw + d < total) ? dws[bi*n_dw + d] : 32'hDEAD_BEEF;
         rx_sop   = (bi == 0);
         rx_eop   = (bi == nb - 1);
         rx_valid = 1'b1;
         wait_accept();
      end
      rx_valid = 1'b0;
      rx_sop   = 1'b0;
      rx_eop   = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
      repeat (6) @(negedge clk);
      check_val("drain", 512'(exp_q.size()), 512'(0));
      @(posedge clk);
      #1;
   endtask

   task automatic check_cnts(input int d, input int e);
      check_val("drop_cnt", 512'(dcnt[sel]), 512'(d));
      check_val("err_cnt", 512'(ecnt[sel]), 512'(e));
   endtask

   task automatic basic_set();
      send_tlp(8'h4A, 1, 8'h00, 3'd0, 12'd4, 0, 9999, -1);
      send_tlp(8'h4A, 4, 8'h12, 3'd0, 12'd100, 0, 9999, -1);
      send_tlp(8'h4A, 16, 8'h33, 3'd0, 12'd64, 0, 9999, -1);
      drain();
      check_cnts(0, 0);
   endtask

   initial begin
      rst_n = 1'b0; rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rx_data = '0;
      sel = 1; n_dw = 8; toggle = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         check_val("rst_valid", 512'(ov[k]), 512'(0));
         check_val("rst_data", od[k], 512'(0));
         check_val("rst_sop_eop", 512'({osop[k], oeop[k], olast[k]}), 512'(0));
         check_val("rst_empty_tag", 512'({oemp[k], otag[k]}), 512'(0));
         check_val("rst_cnts", 512'({dcnt[k], ecnt[k]}), 512'(0));
         check_val("rst_rx_ready", 512'(rrdy[k]), 512'(0));
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 256-bit: basic lengths, stalls, discards, abort, reset mid-packet.
      basic_set();
      toggle = 1'b1;
      send_tlp(8'h4A, 16, 8'h44, 3'd0, 12'd64, 0, 9999, -1);
      drain();
      toggle = 1'b0;
      send_tlp(8'h00, 1, 8'h01, 3'd0, 12'd4, 0, 9999, 0);
      send_tlp(8'h4A, 1, 8'h02, 3'd1, 12'd4, 0, 9999, 0);
      send_tlp(8'h4A, 2, 8'h55, 3'd0, 12'd8, 0, 9999, -1);
      drain();
      check_cnts(1, 1);
      send_tlp(8'h4A, 16, 8'h70, 3'd0, 12'd64, 0, 1, 1);
      send_tlp(8'h4A, 4, 8'h66, 3'd0, 12'd16, 0, 9999, -1);
      drain();
      check_cnts(2, 1);
      send_tlp(8'h4A, 300, 8'h71, 3'd0, 12'd1200, 0, 9999, 0);
      drain();
      check_cnts(3, 1);
      send_tlp(8'h4A, 32, 8'h77, 3'd0, 12'd128, 0, 1, 0);
      rst_n = 1'b0;
      @(negedge clk);
      check_val("rx_ready_in_reset", 512'(rrdy[sel]), 512'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_cnts(0, 0);
      send_tlp(8'h4A, 32, 8'h77, 3'd0, 12'd128, 2, 9999, 0);
      send_tlp(8'h4A, 1, 8'h88, 3'd0, 12'd4, 0, 9999, -1);
      drain();
      check_cnts(0, 0);

      // 128-bit and 512-bit widths.
      sel = 0; n_dw = 4;
      basic_set();
      sel = 2; n_dw = 16;
      basic_set();

      $display("Result: errors=%0d of %0d checks", err_count, chk_count);
      $finish;
   end

endmodule
